// File: rtl/mdio_pkg.sv
// Shared MDIO constants, command record and PHY-init state enum.
// The poll states exist only when MDIO_LINK_POLL_EN is defined.
package mdio_pkg;

  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam logic [4:0] REG_BMCR   = 5'h00;
  localparam logic [4:0] REG_BMSR   = 5'h01;
  localparam logic [4:0] REG_PHYID1 = 5'h02;
  localparam logic [4:0] REG_GBCR   = 5'h09;

  // Autonegotiation enable plus restart; GBCR cleared to stop 1000BASE-T advertisement.
  localparam logic [15:0] BMCR_AN_RESTART = 16'h1340;
  localparam logic [15:0] GBCR_NO_1000    = 16'h0000;

  typedef enum logic [3:0] {
    ST_DELAY,
    ST_WR_GBCR,
    ST_WR_BMCR,
    ST_RD_ID,
    ST_RD_ID_WAIT,
    ST_DONE
`ifdef MDIO_LINK_POLL_EN
    ,
    ST_POLL,
    ST_POLL_WAIT,
    ST_POLL_IDLE
`endif
  } state_e;

  typedef struct packed {
    logic [4:0]  reg_addr;
    logic [15:0] data;
    logic [1:0]  opcode;
  } mdio_cmd_t;

  localparam mdio_cmd_t CMD_IDLE = '{reg_addr: 5'h00, data: 16'h0000, opcode: MDIO_OP_WR};

  function automatic logic is_cmd_state(state_e s);
    return (s == ST_WR_GBCR) || (s == ST_WR_BMCR) || (s == ST_RD_ID)
`ifdef MDIO_LINK_POLL_EN
           || (s == ST_POLL)
`endif
           ;
  endfunction

  function automatic mdio_cmd_t cmd_for_state(state_e s);
    mdio_cmd_t c;
    case (s)
      ST_WR_GBCR: c = '{reg_addr: REG_GBCR,   data: GBCR_NO_1000,    opcode: MDIO_OP_WR};
      ST_WR_BMCR: c = '{reg_addr: REG_BMCR,   data: BMCR_AN_RESTART, opcode: MDIO_OP_WR};
      ST_RD_ID:   c = '{reg_addr: REG_PHYID1, data: 16'h0000,        opcode: MDIO_OP_RD};
`ifdef MDIO_LINK_POLL_EN
      ST_POLL:    c = '{reg_addr: REG_BMSR,   data: 16'h0000,        opcode: MDIO_OP_RD};
`endif
      default:    c = CMD_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdio_phy_init.sv
// Post-reset PHY bring-up over an mdio_master command port: GBCR, BMCR, PHY ID check.
// Define MDIO_LINK_POLL_EN to keep polling BMSR for link status after init.
module mdio_phy_init
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR      = 5'h00,
  parameter logic [19:0] STARTUP_DELAY = 20'hFFFFF,
  parameter int unsigned POLL_INTERVAL = 1_250_000,
  parameter int unsigned RD_TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0]  cmd_opcode,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready,
  input  logic        restart,
  output logic        init_done,
  output logic        link_up,
  output logic        phy_err
);

  if (RD_TIMEOUT < 2 || POLL_INTERVAL < 2) begin : g_bad_params
    $error("mdio_phy_init: RD_TIMEOUT and POLL_INTERVAL must be at least 2");
  end

  localparam int unsigned TMO_W = $clog2(RD_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(RD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [19:0]       delay_cnt_q, delay_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  mdio_cmd_t         cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              init_done_q, init_done_d;
  logic              phy_err_q, phy_err_d;
  logic              cmd_hs, rd_hs, id_bad;

`ifdef MDIO_LINK_POLL_EN
  localparam int unsigned POLL_W = $clog2(POLL_INTERVAL);
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_INTERVAL - 1);

  logic              link_up_q, link_up_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;

  assign data_out_ready = (state_q == ST_RD_ID_WAIT) || (state_q == ST_POLL_WAIT);
  assign link_up        = link_up_q;
`else
  assign data_out_ready = (state_q == ST_RD_ID_WAIT);
  assign link_up        = 1'b0;
`endif

  assign cmd_hs = cmd_valid_q && cmd_ready;
  assign rd_hs  = data_out_valid && data_out_ready;
  assign id_bad = (data_out == 16'h0000) || (data_out == 16'hFFFF);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    init_done_d = init_done_q;
    phy_err_d   = phy_err_q;
`ifdef MDIO_LINK_POLL_EN
    link_up_d   = link_up_q;
    poll_cnt_d  = poll_cnt_q;
`endif

    if (restart) begin
      // Restart beats a same-cycle handshake; the abandoned read's data is never accepted.
      state_d     = ST_WR_GBCR;
      cmd_valid_d = 1'b0;
      init_done_d = 1'b0;
      phy_err_d   = 1'b0;
`ifdef MDIO_LINK_POLL_EN
      link_up_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_DELAY: begin
          if (delay_cnt_q == '0) state_d = ST_WR_GBCR;
          else                   delay_cnt_d = delay_cnt_q - 20'd1;
        end
        ST_WR_GBCR: if (cmd_hs) state_d = ST_WR_BMCR;
        ST_WR_BMCR: if (cmd_hs) state_d = ST_RD_ID;
        ST_RD_ID: begin
          if (cmd_hs) begin
            state_d   = ST_RD_ID_WAIT;
            tmo_cnt_d = TMO_LOAD;
          end
        end
        ST_RD_ID_WAIT: begin
          // A timed-out read is treated as 16'h0000, which is itself an invalid ID.
          if (rd_hs || tmo_cnt_q == '0) begin
            state_d     = ST_DONE;
            init_done_d = 1'b1;
            if (!rd_hs || id_bad) phy_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
          end
        end
`ifdef MDIO_LINK_POLL_EN
        ST_DONE: state_d = ST_POLL;
        ST_POLL: begin
          if (cmd_hs) begin
            state_d   = ST_POLL_WAIT;
            tmo_cnt_d = TMO_LOAD;
          end
        end
        ST_POLL_WAIT: begin
          if (rd_hs || tmo_cnt_q == '0) begin
            state_d    = ST_POLL_IDLE;
            poll_cnt_d = POLL_LOAD;
            link_up_d  = rd_hs && data_out[2];
            if (!rd_hs) phy_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
          end
        end
        ST_POLL_IDLE: begin
          if (poll_cnt_q == '0) state_d = ST_POLL;
          else                  poll_cnt_d = poll_cnt_q - 1'b1;
        end
`else
        ST_DONE: state_d = ST_DONE;
`endif
        default: state_d = ST_DELAY;
      endcase

      // Fields only change when the target state changes, so they hold steady while valid.
      if (is_cmd_state(state_d)) begin
        cmd_d       = cmd_for_state(state_d);
        cmd_valid_d = 1'b1;
      end else if (cmd_hs) begin
        cmd_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DELAY;
      delay_cnt_q <= STARTUP_DELAY;
      tmo_cnt_q   <= '0;
      cmd_q       <= CMD_IDLE;
      cmd_valid_q <= 1'b0;
      init_done_q <= 1'b0;
      phy_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_cnt_q <= delay_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      init_done_q <= init_done_d;
      phy_err_q   <= phy_err_d;
    end
  end

`ifdef MDIO_LINK_POLL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_up_q  <= 1'b0;
      poll_cnt_q <= '0;
    end else begin
      link_up_q  <= link_up_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end
`endif

  assign cmd_phy_addr = PHY_ADDR;
  assign cmd_reg_addr = cmd_q.reg_addr;
  assign cmd_data     = cmd_q.data;
  assign cmd_opcode   = cmd_q.opcode;
  assign cmd_valid    = cmd_valid_q;
  assign init_done    = init_done_q;
  assign phy_err      = phy_err_q;

endmodule

// File: doc/mdio_phy_init.md
MDIO_PHY_INIT -- requirements
Module: mdio_phy_init

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'h00, the MDIO address of the PHY that every command targets.
REQ-002 SHALL have parameter STARTUP_DELAY, default 20'hFFFFF, the number of clk cycles to wait after reset before the first command.
REQ-003 SHALL have parameter POLL_INTERVAL, default 1_250_000, the number of clk cycles between link polls (10 ms at 125 MHz).
REQ-004 SHALL have parameter RD_TIMEOUT, default 4096, the maximum number of clk cycles to wait for read data.
REQ-005 Ports (one clock, `clk`; reset `rst`, asynchronous, active-high):
- clk  in  1  sole clock (125 MHz).
- rst  in  1  async active-high reset.
- cmd_phy_addr  out  5  command PHY address.
- cmd_reg_addr  out  5  command register address.
- cmd_data  out  16  write data.
- cmd_opcode  out  2  2'b01 write, 2'b10 read.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  mdio_master accepts the command.
- data_out  in  16  read data.
- data_out_valid  in  1  read data valid.
- data_out_ready  out  1  read data accept.
- restart  in  1  single-cycle pulse; rerun the init sequence.
- init_done  out  1  init sequence finished.
- link_up  out  1  latest BMSR link status.
- phy_err  out  1  PHY ID invalid or read timeout.

Function
REQ-006 The state sequence SHALL be: DELAY -> WR_GBCR -> WR_BMCR -> RD_ID -> RD_ID_WAIT -> DONE, with POLL -> POLL_WAIT -> POLL_IDLE -> POLL following DONE when polling is enabled.
REQ-007 DELAY SHALL count STARTUP_DELAY cycles down to 0, then advance.
REQ-008 WR_GBCR SHALL issue a write of reg 5'h09 with data 16'h0000, disabling 1000BASE-T advertisement.
REQ-009 WR_BMCR SHALL issue a write of reg 5'h00 with data 16'h1340, enabling and restarting autonegotiation.
REQ-010 RD_ID SHALL issue a read of reg 5'h02; phy_err SHALL be set if the returned value is 16'h0000 or 16'hFFFF.
REQ-011 Command handshake: cmd_valid SHALL be held until the cycle in which cmd_valid && cmd_ready; all cmd_* fields SHALL be stable while valid; transfer occurs on that cycle; the state advances the next cycle.
REQ-012 cmd_phy_addr SHALL always equal PHY_ADDR.
REQ-013 data_out_ready SHALL be 1 only in the *_WAIT states; data is captured when data_out_valid && data_out_ready.
REQ-014 Read timeout: if no data arrives within RD_TIMEOUT cycles of the read being accepted, the block SHALL set phy_err and continue to the next state as if the data were 16'h0000.
REQ-015 init_done SHALL rise on entry to DONE and stay high until reset or restart.
REQ-016 restart SHALL be honoured in any state: drop cmd_valid, clear init_done, link_up and phy_err, and go to WR_GBCR without the delay.
REQ-017 A restart arriving in the same cycle as a cmd handshake SHALL win; the accepted command is abandoned and any resulting data is discarded by the *_WAIT logic.
REQ-018 phy_err SHALL be sticky until reset or restart.
REQ-019 The counters SHALL saturate and never wrap; the delay counter width is 20 bits and the poll and timeout counters are sized by $clog2.

Reset
REQ-020 On rst: state = DELAY, counter = STARTUP_DELAY; cmd_valid, data_out_ready, init_done, link_up and phy_err = 0; cmd_reg_addr = 0, cmd_data = 0, cmd_opcode = 2'b01.
REQ-021 Deassertion of rst SHALL be synchronous to clk, supplied externally.

Configuration
REQ-022 Macro MDIO_LINK_POLL_EN, when defined, SHALL enable polling: after DONE, read reg 5'h01 (BMSR) every POLL_INTERVAL cycles and set link_up to bit 2 of the returned value.
REQ-023 When MDIO_LINK_POLL_EN is undefined, DONE SHALL be terminal, link_up SHALL be tied to 0, and the poll states and poll counter SHALL be absent.

Structure
REQ-024 A shared package mdio_pkg SHALL hold the opcode constants (MDIO_OP_WR = 2'b01, MDIO_OP_RD = 2'b10), the register addresses (BMCR = 0, BMSR = 1, PHYID1 = 2, GBCR = 9), the data constants (16'h1340, 16'h0000) and the state enum.
REQ-025 The block SHALL be a single module with no sub-modules; the command issue/wait logic is shared across states through a common command register.

Verification
REQ-026 Reset, STARTUP_DELAY = 16, cmd_ready = 1 -> first cmd_valid at cycle 17: reg 9, data 0000, op 01.
REQ-027 cmd_ready held low for 50 cycles during WR_BMCR -> cmd_valid stays high, reg 0 and data 1340 stay stable, exactly one transfer occurs.
REQ-028 ID read returns 16'hFFFF -> phy_err = 1, init_done = 1.
REQ-029 RD_TIMEOUT = 8, data_out_valid never asserted -> phy_err = 1 at 8 cycles after acceptance, sequence continues.
REQ-030 With MDIO_LINK_POLL_EN and POLL_INTERVAL = 100, BMSR returns 16'h7949 then 16'h796D -> link_up 0, then 1 after the second poll.
REQ-031 restart pulsed mid WR_BMCR -> init_done = 0, next command is the reg 9 write with no delay.
